// File: rtl/eth_pkg.sv
// Shared constants and framer state encoding for the Ethernet TX path.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;

    localparam int PREAMBLE_LEN = 8;
    localparam int HDR_LEN      = 14;
    localparam int FCS_LEN      = 4;

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    // Shared byte counter must hold the longest state (1500-byte payload).
    localparam int CNT_W = 11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_HEADER   = 3'd2,
        S_PAYLOAD  = 3'd3,
        S_FCS      = 3'd4,
        S_IFG      = 3'd5
    } eth_state_e;

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational CRC-32 (IEEE 802.3, reflected) next-state function, one byte per call.
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] crc_work;

    always_comb begin
        crc_work = crc_in ^ {24'h000000, data_in};
        for (int i = 0; i < 8; i++) begin
            crc_work = crc_work[0] ? ((crc_work >> 1) ^ CRC_POLY) : (crc_work >> 1);
        end
        crc_out = crc_work;
    end

endmodule

// File: rtl/eth_tx_framer.sv
// GMII TX framer: preamble/SFD, MAC header, time-aligned payload, optional FCS, inter-frame gap.
// Define ETH_FCS_EN to build the CRC-32 and emit the FCS; otherwise PAYLOAD goes straight to IFG.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int PLD_LEN = 46,
    parameter int PLD_LAT = 2,
    parameter int IFG_LEN = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_req,
    input  logic        tx_is_ack,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [15:0] eth_type,
    output logic        pld_trig,
    output logic        pld_ack,
    input  logic [7:0]  pld_data,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        tx_busy,
    output logic        tx_done,
    output eth_state_e  dbg_state
);

    // pld_trig is issued at this frame byte position so the source's first byte
    // is sampled into the output register right after the last header byte.
    localparam int TRIG_POS = PREAMBLE_LEN + HDR_LEN - PLD_LAT;
    localparam eth_state_e TRIG_STATE = (TRIG_POS < PREAMBLE_LEN) ? S_PREAMBLE : S_HEADER;
    localparam logic [CNT_W-1:0] TRIG_CNT = (TRIG_POS < PREAMBLE_LEN) ?
                                             CNT_W'(TRIG_POS) : CNT_W'(TRIG_POS - PREAMBLE_LEN);

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_LEN - 1);
    localparam logic [CNT_W-1:0] PLD_LAST = CNT_W'(PLD_LEN - 1);
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_LEN - 1);

    eth_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [8*HDR_LEN-1:0] hdr_q, hdr_d;
    logic                 pld_ack_q, pld_ack_d;
    logic                 pld_trig_q, pld_trig_d;
    logic [7:0]           txd_q, txd_d;
    logic                 tx_en_q, tx_en_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_done_q, tx_done_d;
    logic                 accept;

    // Request handshake: tx_req is a one-cycle strobe taken only when the
    // framer is idle and tx_busy is low; anything else is dropped, never queued.
    assign accept = tx_req && (state_q == S_IDLE) && !tx_busy_q;

`ifdef ETH_FCS_EN
    localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(FCS_LEN - 1);

    logic [31:0] crc_q, crc_d, crc_upd;
    logic [7:0]  fcs_byte;

    eth_crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data_in (txd_d),
        .crc_out (crc_upd)
    );

    always_comb begin
        crc_d = crc_q;
        if (accept) begin
            crc_d = CRC_INIT;
        end else if (state_q == S_HEADER || state_q == S_PAYLOAD) begin
            crc_d = crc_upd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    // FCS goes out least-significant byte first, complemented.
    assign fcs_byte = ~crc_q[{cnt_q[1:0], 3'b000} +: 8];
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        hdr_d      = hdr_q;
        pld_ack_d  = pld_ack_q;
        txd_d      = 8'h00;
        tx_en_d    = 1'b0;
        tx_busy_d  = (state_q != S_IDLE);
        tx_done_d  = 1'b0;
        pld_trig_d = (state_q == TRIG_STATE) && (cnt_q == TRIG_CNT);

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d   = S_PREAMBLE;
                    hdr_d     = {dst_mac, src_mac, eth_type};
                    pld_ack_d = tx_is_ack;
                end
            end
            S_PREAMBLE: begin
                tx_en_d = 1'b1;
                txd_d   = (cnt_q == PRE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
                if (cnt_q == PRE_LAST) begin
                    state_d = S_HEADER;
                    cnt_d   = '0;
                end
            end
            S_HEADER: begin
                tx_en_d = 1'b1;
                txd_d   = hdr_q[8*HDR_LEN-1 -: 8];
                hdr_d   = {hdr_q[8*HDR_LEN-9:0], 8'h00};
                if (cnt_q == HDR_LAST) begin
                    state_d = S_PAYLOAD;
                    cnt_d   = '0;
                end
            end
            S_PAYLOAD: begin
                tx_en_d = 1'b1;
                txd_d   = pld_data;
                if (cnt_q == PLD_LAST) begin
`ifdef ETH_FCS_EN
                    state_d = S_FCS;
`else
                    state_d = S_IFG;
`endif
                    cnt_d   = '0;
                end
            end
`ifdef ETH_FCS_EN
            S_FCS: begin
                tx_en_d = 1'b1;
                txd_d   = fcs_byte;
                if (cnt_q == FCS_LAST) begin
                    state_d = S_IFG;
                    cnt_d   = '0;
                end
            end
`endif
            S_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    tx_done_d = 1'b1;
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hdr_q      <= '0;
            pld_ack_q  <= 1'b0;
            pld_trig_q <= 1'b0;
            txd_q      <= 8'h00;
            tx_en_q    <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hdr_q      <= hdr_d;
            pld_ack_q  <= pld_ack_d;
            pld_trig_q <= pld_trig_d;
            txd_q      <= txd_d;
            tx_en_q    <= tx_en_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign pld_trig   = pld_trig_q;
    assign pld_ack    = pld_ack_q;
    assign gmii_txd   = txd_q;
    assign gmii_tx_en = tx_en_q;
    assign tx_busy    = tx_busy_q;
    assign tx_done    = tx_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Bench for eth_tx_framer: default instance (46/2/12) plus a PLD_LEN=60, PLD_LAT=5 instance.
// Frame bytes are predicted into expected queues and compared as they appear on GMII.
module tb_eth_tx_framer;
    import eth_pkg::*;

    localparam int PLD_LEN  = 46;
    localparam int PLD_LAT  = 2;
    localparam int IFG_LEN  = 12;
    localparam int PLD_LEN1 = 60;
    localparam int PLD_LAT1 = 5;
`ifdef ETH_FCS_EN
    localparam int FCS_B = 4;
`else
    localparam int FCS_B = 0;
`endif
    localparam int FRAME_LEN  = 22 + PLD_LEN + FCS_B;
    localparam int FRAME_LEN1 = 22 + PLD_LEN1 + FCS_B;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        tx_req, tx_req1, tx_is_ack;
    logic [47:0] dst, src;
    logic [15:0] typ;
    logic        pld_trig0, pld_ack0, en0, busy0, done0;
    logic        pld_trig1, pld_ack1, en1, busy1, done1;
    logic [7:0]  pld_data0, pld_data1, txd0, txd1;
    eth_state_e  st0, st1;

    eth_tx_framer #(.PLD_LEN(PLD_LEN), .PLD_LAT(PLD_LAT), .IFG_LEN(IFG_LEN)) dut (
        .clk(clk), .rst(rst), .tx_req(tx_req), .tx_is_ack(tx_is_ack),
        .dst_mac(dst), .src_mac(src), .eth_type(typ),
        .pld_trig(pld_trig0), .pld_ack(pld_ack0), .pld_data(pld_data0),
        .gmii_txd(txd0), .gmii_tx_en(en0), .tx_busy(busy0), .tx_done(done0),
        .dbg_state(st0)
    );

    eth_tx_framer #(.PLD_LEN(PLD_LEN1), .PLD_LAT(PLD_LAT1), .IFG_LEN(IFG_LEN)) dut1 (
        .clk(clk), .rst(rst), .tx_req(tx_req1), .tx_is_ack(tx_is_ack),
        .dst_mac(dst), .src_mac(src), .eth_type(typ),
        .pld_trig(pld_trig1), .pld_ack(pld_ack1), .pld_data(pld_data1),
        .gmii_txd(txd1), .gmii_tx_en(en1), .tx_busy(busy1), .tx_done(done1),
        .dbg_state(st1)
    );

    logic [31:0] crc_in, crc_out;
    logic [7:0]  crc_data;
    eth_crc32_d8 u_crc (.crc_in(crc_in), .data_in(crc_data), .crc_out(crc_out));

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference helpers ----------------
    function automatic logic [7:0] pay_byte(input logic [7:0] seed, input int k);
        int v;
        v = int'(seed) * 131 + k * 29 + (k >> 3) * 7;
        return v[7:0];
    endfunction

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [47:0] rnd48();
        return {16'($urandom()), $urandom()};
    endfunction

    logic [7:0] exp_q[$];
    logic [7:0] exp1_q[$];

    task automatic push_frame(input int which, input logic [47:0] d, input logic [47:0] s,
                              input logic [15:0] t, input logic [7:0] seed, input int plen);
        logic [7:0]   b[$];
        logic [111:0] hdr;
        logic [31:0]  c;
        for (int i = 0; i < 7; i++) b.push_back(8'h55);
        b.push_back(8'hD5);
        hdr = {d, s, t};
        for (int i = 0; i < 14; i++) b.push_back(hdr[111 - 8*i -: 8]);
        for (int i = 0; i < plen; i++) b.push_back(pay_byte(seed, i));
        if (FCS_B == 4) begin
            c = 32'hFFFFFFFF;
            for (int i = 8; i < int'(b.size()); i++) c = crc_byte(c, b[i]);
            c = ~c;
            b.push_back(c[7:0]);
            b.push_back(c[15:8]);
            b.push_back(c[23:16]);
            b.push_back(c[31:24]);
        end
        foreach (b[i]) begin
            if (which == 0) exp_q.push_back(b[i]);
            else            exp1_q.push_back(b[i]);
        end
    endtask

    // ---------------- payload source models ----------------
    logic [7:0] cur_seed0 = 8'h00, act_seed0 = 8'h00;
    logic [7:0] cur_seed1 = 8'h00, act_seed1 = 8'h00;
    int trig_at0 = -1000, trig_at1 = -1000;

    always @(negedge clk) begin
        int k;
        if (pld_trig0) begin trig_at0 = cyc; act_seed0 = cur_seed0; end
        k = cyc + 1 - trig_at0 - PLD_LAT;
        if (k >= 0 && k < PLD_LEN) pld_data0 = pay_byte(act_seed0, k);
        else                       pld_data0 = 8'($urandom_range(0, 255));
    end

    always @(negedge clk) begin
        int k;
        if (pld_trig1) begin trig_at1 = cyc; act_seed1 = cur_seed1; end
        k = cyc + 1 - trig_at1 - PLD_LAT1;
        if (k >= 0 && k < PLD_LEN1) pld_data1 = pay_byte(act_seed1, k);
        else                        pld_data1 = 8'($urandom_range(0, 255));
    end

    // ---------------- output monitors ----------------
    int fb0 = 0, last_len0 = 0, start0 = 0, idle0 = 1000, gap0 = 0, done_idle0 = 0;
    int trig_cyc0 = 0, trig_cnt0 = 0;
    logic trig_ack0 = 1'b0, en_prev0 = 1'b0, exp_ack0 = 1'b0;

    always @(negedge clk) begin
        if (en0) begin
            if (fb0 == 0) begin start0 = cyc; gap0 = idle0; end
            if (exp_q.size() == 0) check("extra_byte", 32'(exp_q.size()), 32'd1);
            else                   check("byte", 32'(txd0), 32'(exp_q.pop_front()));
            fb0++;
            idle0 = 0;
        end else begin
            check("idle_txd", 32'(txd0), 32'd0);
            if (en_prev0) begin last_len0 = fb0; fb0 = 0; end
            idle0++;
        end
        if (done0) done_idle0 = idle0;
        if (pld_trig0) begin trig_cyc0 = cyc; trig_cnt0++; trig_ack0 = pld_ack0; end
        en_prev0 = en0;
    end

    int fb1 = 0, last_len1 = 0, start1 = 0, trig_cyc1 = 0;
    logic en_prev1 = 1'b0;

    always @(negedge clk) begin
        if (en1) begin
            if (fb1 == 0) start1 = cyc;
            if (exp1_q.size() == 0) check("extra_byte1", 32'(exp1_q.size()), 32'd1);
            else                    check("byte1", 32'(txd1), 32'(exp1_q.pop_front()));
            fb1++;
        end else begin
            check("idle_txd1", 32'(txd1), 32'd0);
            if (en_prev1) begin last_len1 = fb1; fb1 = 0; end
        end
        if (pld_trig1) trig_cyc1 = cyc;
        en_prev1 = en1;
    end

    // ---------------- driver tasks (called on a negedge) ----------------
    task automatic send0(input logic ack, input logic [47:0] d, input logic [47:0] s,
                         input logic [15:0] t);
        cur_seed0 = 8'($urandom_range(0, 255));
        push_frame(0, d, s, t, cur_seed0, PLD_LEN);
        exp_ack0  = ack;
        tx_req    = 1'b1;
        tx_is_ack = ack;
        dst = d; src = s; typ = t;
        @(negedge clk);
        tx_req    = 1'b0;
        tx_is_ack = ~ack;
        dst = rnd48(); src = rnd48(); typ = 16'($urandom());
        check("busy_lat", 32'(busy0), 32'd0);
        check("en_lat", 32'(en0), 32'd0);
        @(negedge clk);
        check("busy_on", 32'(busy0), 32'd1);
        check("en_on", 32'(en0), 32'd1);
    endtask

    task automatic finish0(input bit poke_done);
        int n;
        n = 0;
        while (!done0 && n < 5000) begin @(negedge clk); n++; end
        check("done_seen", 32'(done0), 32'd1);
        check("busy_in_done", 32'(busy0), 32'd1);
        if (poke_done) begin
            tx_req = 1'b1;
            dst = rnd48(); src = rnd48(); typ = 16'($urandom());
        end
        @(negedge clk);
        tx_req = 1'b0;
        check("busy_off", 32'(busy0), 32'd0);
        check("state_idle", 32'(st0), 32'(S_IDLE));
        check("frame_len", 32'(last_len0), 32'(FRAME_LEN));
        check("ifg_len", 32'(done_idle0), 32'(IFG_LEN));
        check("exp_empty", 32'(exp_q.size()), 32'd0);
        check("trig_pos", 32'(trig_cyc0 - start0), 32'(22 - PLD_LAT));
        check("trig_ack", 32'(trig_ack0), 32'(exp_ack0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t_cnt, n;
        tx_req = 1'b0; tx_req1 = 1'b0; tx_is_ack = 1'b0;
        dst = '0; src = '0; typ = '0;

        // standalone CRC on "123456789"
        crc_in = 32'hFFFFFFFF;
        crc_data = 8'h00;
        for (int i = 0; i < 9; i++) begin
            crc_data = 8'h31 + 8'(i);
            #1;
            crc_in = crc_out;
        end
        check("crc_check", ~crc_in, 32'hCBF43926);

        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd0), 32'd0);
        check("rst_en", 32'(en0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_trig", 32'(pld_trig0), 32'd0);
        check("rst_ack", 32'(pld_ack0), 32'd0);
        check("rst_state", 32'(st0), 32'(S_IDLE));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ARP request example frame
        send0(1'b0, 48'hFFFF_FFFF_FFFF, 48'h0023_CD76_631A, 16'h0806);
        finish0(1'b0);
        repeat (3) @(negedge clk);

        // reply frame; a mid-frame request and a tx_done-cycle request must both be dropped
        send0(1'b1, rnd48(), rnd48(), 16'h0806);
        repeat (2) @(negedge clk);
        tx_req = 1'b1; tx_is_ack = 1'b0;
        dst = rnd48(); src = rnd48(); typ = 16'($urandom());
        @(negedge clk);
        tx_req = 1'b0;
        finish0(1'b1);

        // earliest acceptance: IFG_LEN idle cycles, then the done cycle's dropped slot
        // and the cycle where busy has just fallen
        send0(1'($urandom_range(0, 1)), rnd48(), rnd48(), 16'($urandom()));
        finish0(1'b0);
        check("b2b_gap", 32'(gap0), 32'(IFG_LEN + 2));

        // reset while payload byte 10 is on the wire
        repeat (4) @(negedge clk);
        send0(1'b1, rnd48(), rnd48(), 16'h0806);
        repeat (32) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_en", 32'(en0), 32'd0);
        check("mid_rst_txd", 32'(txd0), 32'd0);
        check("mid_rst_busy", 32'(busy0), 32'd0);
        check("mid_rst_state", 32'(st0), 32'(S_IDLE));
        exp_q.delete();
        t_cnt = trig_cnt0;
        repeat (40) @(negedge clk);
        check("no_trig_after_rst", 32'(trig_cnt0 - t_cnt), 32'd0);

        // tx_req together with rst is dropped
        rst = 1'b1; tx_req = 1'b1;
        @(negedge clk);
        rst = 1'b0; tx_req = 1'b0;
        repeat (3) @(negedge clk);
        check("req_with_rst_busy", 32'(busy0), 32'd0);
        check("req_with_rst_en", 32'(en0), 32'd0);

        // complete frames after reset, random fields and spacing
        for (int f = 0; f < 4; f++) begin
            send0(1'($urandom_range(0, 1)), rnd48(), rnd48(), 16'($urandom()));
            finish0(1'b0);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        // second geometry: PLD_LEN=60, PLD_LAT=5
        cur_seed1 = 8'($urandom_range(0, 255));
        dst = rnd48(); src = rnd48(); typ = 16'h0806; tx_is_ack = 1'b1;
        push_frame(1, dst, src, typ, cur_seed1, PLD_LEN1);
        tx_req1 = 1'b1;
        @(negedge clk);
        tx_req1 = 1'b0;
        n = 0;
        while (!done1 && n < 5000) begin @(negedge clk); n++; end
        check("done1_seen", 32'(done1), 32'd1);
        @(negedge clk);
        check("frame_len1", 32'(last_len1), 32'(FRAME_LEN1));
        check("trig_pos1", 32'(trig_cyc1 - start1), 32'(22 - PLD_LAT1));
        check("exp1_empty", 32'(exp1_q.size()), 32'd0);
        check("busy1_off", 32'(busy1), 32'd0);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
